// File: rtl/fifo_wr_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
//   state_e          : arbiter FSM state (IDLE, BURST)
//   DEF_NUM_REQ/...  : default parameter values
//   clog2()          : ceiling log2 for constant width calculations
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BURST_MAX = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // clog2(1)=0, clog2(2)=1, clog2(5)=3
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester / FIFO side bundle of the write arbiter.
//   req, data_in, fifo_full      : driven by requesters and the FIFO
//   gnt, ack, fifo_write, fifo_data : driven by the arbiter
//   modport slave  : arbiter view
//   modport master : environment view (requesters + FIFO)
interface fifo_wr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic                      fifo_full;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic                      fifo_write;
  logic [DATA_W-1:0]         fifo_data;

  modport slave (
    input  req, data_in, fifo_full,
    output gnt, ack, fifo_write, fifo_data
  );

  modport master (
    output req, data_in, fifo_full,
    input  gnt, ack, fifo_write, fifo_data
  );
endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req        : request vector
//   last_owner : index of the previous owner; search starts at last_owner+1
//   pick       : one-hot winner (zero when no request)
//   valid      : any request present
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  always_comb begin
    int   idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: NUM_REQ requesters share one FIFO write port in bursts of up
// to BURST_MAX words, arbitrated round-robin.
//   clk, reset : clock, async active-low reset
//   bus        : fifo_wr_arb_if.slave (req/data_in/fifo_full in,
//                gnt/ack/fifo_write/fifo_data out)
//   stall_cnt, word_cnt : statistics, present only with FIFO_WR_ARB_STATS_EN
// A grant is taken in IDLE and writing starts in BURST, so every burst is
// followed by at least one IDLE cycle, bounding any requester's run.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic          clk,
  input  logic          reset,
  fifo_wr_arb_if.slave  bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [31:0]   word_cnt
`endif
);

  localparam int OW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int BW = clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]      last_owner_q, last_owner_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_vld;
  logic [OW-1:0]      pick_idx;
  logic               req_own;
  logic               wr;

  rr_pick #(.NUM_REQ(NUM_REQ), .OW(OW)) u_rr_pick (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .pick       (pick),
    .valid      (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = OW'(i);
  end

  assign req_own = bus.req[owner_q];
  assign wr      = (state_q == BURST) && req_own && !bus.fifo_full;

  assign bus.gnt        = gnt_q;
  assign bus.fifo_write = wr;
  assign bus.ack        = wr ? gnt_q : '0;
  assign bus.fifo_data  = (gnt_q != '0) ? bus.data_in[int'(owner_q)*DATA_W +: DATA_W]
                                        : '0;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (pick_vld && !bus.fifo_full) begin
          gnt_d      = pick;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (wr) beat_cnt_d = beat_cnt_q + 1'b1;
        // Full with req still high falls through: everything holds (stall).
        if (!req_own || (wr && beat_cnt_q == BEAT_LAST)) begin
          state_d      = IDLE;
          gnt_d        = '0;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == BURST && req_own && bus.fifo_full && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    word_cnt_d = word_cnt_q + {31'd0, wr};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign word_cnt  = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed vector table, hand sequences for stall,
// early release, mid-burst reset and round-robin order, then random traffic
// checked against an owner/word-count reference model.
module tb_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.NUM_REQ(N), .DATA_W(DW)) bus();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [31:0] word_cnt;
`endif

  fifo_wr_arb #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .word_cnt  (word_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 none), words in this burst, last owner.
  int          m_owner, m_words, m_last;
  int unsigned m_stall;
  logic [31:0] m_wc;
  logic [DW-1:0] dat [N];
  logic [N-1:0]  s_gnt;
  logic          s_wr;

  typedef struct {
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] gnt;
    logic         wr;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_words = 0;
    m_last  = N - 1;
    m_stall = 0;
    m_wc    = '0;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic f);
    bus.req       = r;
    bus.fifo_full = f;
    for (int i = 0; i < N; i++) begin
      dat[i] = $urandom;
      bus.data_in[i*DW +: DW] = dat[i];
    end
  endtask

  task automatic model_step();
    logic w;
    logic found;
    int   idx;
    if (m_owner < 0) begin
      found = 1'b0;
      if (!bus.fifo_full) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && bus.req[idx]) begin
            found   = 1'b1;
            m_owner = idx;
            m_words = 0;
          end
        end
      end
    end else begin
      w = bus.req[m_owner] && !bus.fifo_full;
      if (w) m_wc = m_wc + 32'd1;
      if (bus.req[m_owner] && bus.fifo_full && m_stall < 65535) m_stall++;
      if (!bus.req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (w) begin
        m_words++;
        if (m_words == BM) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  endtask

  // One clock: drive at negedge, compare just before posedge, advance model.
  task automatic cyc(input logic [N-1:0] r, input logic f);
    logic [N-1:0]  eg;
    logic          ew;
    logic [DW-1:0] ed;
    @(negedge clk);
    drive(r, f);
    #2;
    eg = '0;
    ed = '0;
    ew = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed = dat[m_owner];
      ew = bus.req[m_owner] && !bus.fifo_full;
    end
    chk("gnt", 64'(bus.gnt), 64'(eg));
    chk("fifo_write", 64'(bus.fifo_write), 64'(ew));
    chk("ack", 64'(bus.ack), ew ? 64'(eg) : 64'd0);
    chk("fifo_data", 64'(bus.fifo_data), 64'(ed));
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("word_cnt", 64'(word_cnt), 64'(m_wc));
`endif
    s_gnt = bus.gnt;
    s_wr  = bus.fifo_write;
    model_step();
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_gnt"}, 64'(bus.gnt), 64'd0);
    chk({nm, "_wr"}, 64'(bus.fifo_write), 64'd0);
    chk({nm, "_ack"}, 64'(bus.ack), 64'd0);
    chk({nm, "_data"}, 64'(bus.fifo_data), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive('0, 1'b0);
    #1;
    model_reset();
    chk_idle_outputs("reset");
`ifdef FIFO_WR_ARB_STATS_EN
    chk("reset_stall", 64'(stall_cnt), 64'd0);
    chk("reset_words", 64'(word_cnt), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int order[$];
    int nwr;
    logic [N-1:0] prev, r;
    int exp_order[5];

    tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[2]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[3]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[7]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[10] = '{4'b0001, 1'b1, 4'b0000, 1'b0};
    tbl[11] = '{4'b0001, 1'b1, 4'b0000, 1'b0};
    tbl[12] = '{4'b0001, 1'b0, 4'b0000, 1'b0};
    tbl[13] = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    exp_order = '{0, 1, 2, 3, 0};

    bus.req = '0;
    bus.fifo_full = 1'b0;
    bus.data_in = '0;
    model_reset();

    // Single requester bursts, then grant blocked by full in IDLE.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].req, tbl[i].full);
      chk($sformatf("tbl%0d_gnt", i), 64'(s_gnt), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_wr", i), 64'(s_wr), 64'(tbl[i].wr));
    end

    // All requesters: round-robin order 0,1,2,3,0, four words each.
    do_reset();
    prev = '0;
    nwr  = 0;
    for (int c = 0; c < 25; c++) begin
      cyc(4'b1111, 1'b0);
      chk("rr_onehot", 64'($onehot0(s_gnt)), 64'd1);
      if (s_wr) nwr++;
      if (prev == '0 && s_gnt != '0)
        for (int i = 0; i < N; i++) if (s_gnt[i]) order.push_back(i);
      prev = s_gnt;
    end
    chk("rr_grants", 64'(order.size()), 64'd5);
    for (int k = 0; k < 5 && k < order.size(); k++)
      chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(exp_order[k]));
    chk("rr_words", 64'(nwr), 64'd20);

    // Owner 2 stalls three cycles after its first word.
    do_reset();
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("stall_first_wr", 64'(s_wr), 64'd1);
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0100, 1'b1);
      chk("stall_gnt", 64'(s_gnt), 64'h4);
      chk("stall_wr", 64'(s_wr), 64'd0);
    end
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0100, 1'b0);
      chk("stall_resume_wr", 64'(s_wr), 64'd1);
    end
    cyc(4'b0100, 1'b0);
    chk("stall_end_gnt", 64'(s_gnt), 64'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
`endif

    // Owner 1 drops req after two words; next grant goes to 3, not 0.
    do_reset();
    cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b1001, 1'b0);
    chk("drop_no_wr", 64'(s_wr), 64'd0);
    cyc(4'b1001, 1'b0);
    chk("drop_idle", 64'(s_gnt), 64'd0);
    cyc(4'b1001, 1'b0);
    chk("drop_next_owner", 64'(s_gnt), 64'h8);

    // Reset in the middle of a burst of owner 0.
    do_reset();
    cyc(4'b0011, 1'b0);
    cyc(4'b0011, 1'b0);
    chk("midrst_pre_wr", 64'(s_wr), 64'd1);
    @(negedge clk);
    drive(4'b0011, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    model_reset();
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0011, 1'b0);
    cyc(4'b0011, 1'b0);
    chk("midrst_regrant0", 64'(s_gnt), 64'h1);

    // Random traffic against the model.
    do_reset();
    r = 4'b0101;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) r = N'($urandom);
      cyc(r, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
